// File: rtl/kpn_fifo_channel.sv
// Single-clock KPN token FIFO with registered read data and registered status flags.
// Optional sticky overflow/underflow flags are built when KPN_FIFO_ERR_FLAGS_EN is defined.
module kpn_fifo_channel #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
`ifdef KPN_FIFO_ERR_FLAGS_EN
  output logic                  overflow_err,
  output logic                  underflow_err,
`endif
  output logic [ADDR_WIDTH:0]   count
);

  // Handshake: a write is taken on an edge where wr_en=1 and full=0; a read is
  // taken where rd_en=1 and empty=0, and its token appears on data_out with a
  // one-cycle data_valid pulse after that edge. Rejected requests leave all state alone.

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH:0]   count_nxt;

  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    count_nxt = count;
    if (wr_acc && !rd_acc)
      count_nxt = count + 1'b1;
    else if (rd_acc && !wr_acc)
      count_nxt = count - 1'b1;
  end

  // Storage carries no reset; slots are only ever read after being written.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset)
      mem[wr_ptr] <= data_in;
  end

  // Pointers are ADDR_WIDTH wide, so DEPTH being a power of two gives the wrap for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == DEPTH_CNT);
    end
  end

`ifdef KPN_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_en && full)
        overflow_err <= 1'b1;
      if (rd_en && empty)
        underflow_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed + random bench for kpn_fifo_channel: a queue model of the FIFO feeds an
// expected-output queue that is checked whenever data_valid is due.
module tb_kpn_fifo_channel;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [W-1:0]  data_in;
  logic          full;
  logic          rd_en;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          empty;
  logic [3:0]    count;
`ifdef KPN_FIFO_ERR_FLAGS_EN
  logic          overflow_err;
  logic          underflow_err;
  logic          ovf_m;
  logic          unf_m;
`endif

  kpn_fifo_channel dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .full       (full),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .empty      (empty),
`ifdef KPN_FIFO_ERR_FLAGS_EN
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
`endif
    .count      (count)
  );

  always #5 clk = ~clk;

  int           tests_run = 0;
  int           fails     = 0;
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check({tag, ".full"},  32'(full),  32'(model_q.size() == 8));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
`ifdef KPN_FIFO_ERR_FLAGS_EN
    check({tag, ".ovf"}, 32'(overflow_err),  32'(ovf_m));
    check({tag, ".unf"}, 32'(underflow_err), 32'(unf_m));
`endif
  endtask

  // One clock: drive requests, advance the model, then compare 1 time unit after the edge.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r, input string tag);
    logic pend_rd;
    logic m_full;
    logic m_empty;
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    m_full  = (model_q.size() == 8);
    m_empty = (model_q.size() == 0);
    pend_rd = r && !m_empty;
    if (pend_rd)
      exp_q.push_back(model_q.pop_front());
    if (w && !m_full)
      model_q.push_back(d);
`ifdef KPN_FIFO_ERR_FLAGS_EN
    if (w && m_full)  ovf_m = 1'b1;
    if (r && m_empty) unf_m = 1'b1;
`endif
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(data_valid), 32'(pend_rd));
    if (pend_rd) begin
      last_out = exp_q.pop_front();
      check({tag, ".data"}, 32'(data_out), 32'(last_out));
    end else begin
      check({tag, ".hold"}, 32'(data_out), 32'(last_out));
    end
    check_status(tag);
  endtask

  task automatic do_reset(input logic w, input string tag);
    reset   = 1'b1;
    wr_en   = w;
    rd_en   = 1'b0;
    data_in = 16'hdead;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_q.delete();
    exp_q.delete();
    last_out = '0;
`ifdef KPN_FIFO_ERR_FLAGS_EN
    ovf_m = 1'b0;
    unf_m = 1'b0;
`endif
    check({tag, ".valid"}, 32'(data_valid), 32'd0);
    check({tag, ".data"},  32'(data_out),   32'd0);
    check_status(tag);
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0; last_out = '0;
    @(negedge clk);

    // Reset with a concurrent write request.
    do_reset(1'b1, "rst0");

    // Fill with 0x0001..0x0008, then a 9th write must be dropped.
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, "fill");
    check("fill.count8", 32'(count), 32'd8);
    check("fill.full8",  32'(full),  32'd1);
    step(1'b1, 16'h0009, 1'b0, "wr_full");
    check("wr_full.count", 32'(count), 32'd8);

    // Drain in order; pulses land one cycle after each rd_en.
    for (int i = 1; i <= 8; i++) step(1'b0, '0, 1'b1, "drain");
    check("drain.empty", 32'(empty), 32'd1);
    check("drain.count", 32'(count), 32'd0);

    // Read on empty is rejected (and flags underflow when built).
    step(1'b0, '0, 1'b1, "rd_empty");
    step(1'b0, '0, 1'b0, "idle");

    // 12 writes / 12 reads overlapped so both pointers wrap.
    for (int i = 0; i < 4; i++)  step(1'b1, 16'h0100 + W'(i), 1'b0, "wrap_w");
    for (int i = 4; i < 12; i++) step(1'b1, 16'h0100 + W'(i), 1'b1, "wrap_wr");
    for (int i = 0; i < 4; i++)  step(1'b0, '0, 1'b1, "wrap_r");

    // Steady state at count=4 with simultaneous read and write.
    for (int i = 0; i < 4; i++)  step(1'b1, 16'h0200 + W'(i), 1'b0, "pre4");
    for (int i = 0; i < 10; i++) step(1'b1, 16'h0300 + W'(i), 1'b1, "both4");
    check("both4.count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++)  step(1'b0, '0, 1'b1, "post4");
    step(1'b1, 16'h0abc, 1'b1, "both_empty");
    check("both_empty.count", 32'(count), 32'd1);
    step(1'b0, '0, 1'b1, "tail");
    step(1'b0, '0, 1'b0, "tail_idle");

    // Write on full after refilling.
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0400 + W'(i), 1'b0, "refill");
    step(1'b1, 16'hbeef, 1'b0, "ovf");
    step(1'b1, 16'hbeef, 1'b1, "full_both");

    // Random traffic.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), W'($urandom_range(0, 16'hffff)),
           1'($urandom_range(0, 1)), "rand");

    // Mid-stream reset at count=5 with wr_en held high.
    do_reset(1'b0, "rst1");
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0500 + W'(i), 1'b0, "fill5");
    check("fill5.count", 32'(count), 32'd5);
    do_reset(1'b1, "rst_mid");
    step(1'b0, '0, 1'b1, "post_rst_rd");
    step(1'b0, '0, 1'b0, "post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
